// File: rtl/mask_gen_pkg.sv
// Shared types for the thermometer/range mask generator.
// Holds mode codes, FSM state encoding and the count clamp helper.
package mask_gen_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUILD = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_LEFT      = 2'd0;
   localparam logic [1:0] MODE_RIGHT     = 2'd1;
   localparam logic [1:0] MODE_RANGE     = 2'd2;
   localparam logic [1:0] MODE_INV_RANGE = 2'd3;

   function automatic int unsigned clamp_cnt(
      input int unsigned cnt,
      input int unsigned w
   );
      return (cnt > w) ? w : cnt;
   endfunction

endpackage

// File: rtl/mask_gen_param_if.sv
// Request/result bus of the mask generator.
// master: scan controller (drives i_*), slave: generator (drives o_*).
interface mask_gen_param_if #(
   parameter int W = 32
);
   localparam int CW = $clog2(W) + 1;

   logic          i_clr;
   logic          i_trig;
   logic [1:0]    i_mode;
   logic [CW-1:0] i_cnt_a;
   logic [CW-1:0] i_cnt_b;
   logic          o_busy;
   logic          o_done;
   logic [W-1:0]  o_mask;

   modport master (
      output i_clr, i_trig, i_mode, i_cnt_a, i_cnt_b,
      input  o_busy, o_done, o_mask
   );

   modport slave (
      input  i_clr, i_trig, i_mode, i_cnt_a, i_cnt_b,
      output o_busy, o_done, o_mask
   );
endinterface

// File: rtl/mask_gen_param_therm_builder.sv
// One latched count and its thermometer register, filled one count bit per step.
// Ports: i_load latches i_cnt and zeroes o_therm; i_step applies bit i_k.
module therm_builder #(
   parameter int W  = 32,
   parameter int CW = $clog2(W) + 1,
   parameter int KW = $clog2(CW)
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_clr,
   input  logic          i_load,
   input  logic          i_step,
   input  logic [KW-1:0] i_k,
   input  logic [CW-1:0] i_cnt,
   output logic [W-1:0]  o_therm
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] fill_n;
   logic [W-1:0]  therm_n;

   // Bit k adds 2^k ones at the LSB end; 2^k == W only when the
   // clamped count is exactly W, which means all ones.
   always_comb begin
      fill_n = CW'(1) << i_k;
      if (fill_n >= CW'(W))
         therm_n = '1;
      else
         therm_n = (o_therm << fill_n) | ~({W{1'b1}} << fill_n);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         cnt_q   <= '0;
         o_therm <= '0;
      end else if (i_clr) begin
         cnt_q   <= '0;
         o_therm <= '0;
      end else if (i_load) begin
         cnt_q   <= i_cnt;
         o_therm <= '0;
      end else if (i_step && cnt_q[i_k]) begin
         o_therm <= therm_n;
      end
   end

endmodule

// File: rtl/mask_gen_param.sv
// Iterative left/right/range/inverted-range mask generator with trig/done handshake.
// Ports: i_clk, i_rstn (async, active-low), bus (slave: clr/trig/mode/counts in, busy/done/mask out).
module mask_gen_param
   import mask_gen_pkg::*;
#(
   parameter int W = 32
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   mask_gen_param_if.slave bus
);

   localparam int CW = $clog2(W) + 1;
   localparam int KW = $clog2(CW);

   state_t        state_q;
   state_t        state_d;
   logic [KW-1:0] k_q;
   logic [1:0]    mode_q;
   logic          done_q;
   logic          done_d;
   logic [W-1:0]  mask_q;
   logic [W-1:0]  mask_d;
   logic [W-1:0]  res;
   logic [W-1:0]  rev;
   logic [W-1:0]  therm_a;
   logic [W-1:0]  therm_b;
   logic [CW-1:0] cnt_a_c;
   logic [CW-1:0] cnt_b_c;
   logic          load;
   logic          step;

   assign cnt_a_c = CW'(clamp_cnt(32'(bus.i_cnt_a), W));
   assign cnt_b_c = CW'(clamp_cnt(32'(bus.i_cnt_b), W));

   assign load = (state_q == IDLE) && bus.i_trig && !bus.i_clr;
   assign step = (state_q == BUILD) && !bus.i_clr;

   therm_builder #(.W(W), .CW(CW), .KW(KW)) u_a (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_clr   (bus.i_clr),
      .i_load  (load),
      .i_step  (step),
      .i_k     (k_q),
      .i_cnt   (cnt_a_c),
      .o_therm (therm_a)
   );

   therm_builder #(.W(W), .CW(CW), .KW(KW)) u_b (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_clr   (bus.i_clr),
      .i_load  (load),
      .i_step  (step),
      .i_k     (k_q),
      .i_cnt   (cnt_b_c),
      .o_therm (therm_b)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= IDLE;
         k_q     <= '0;
         mode_q  <= MODE_LEFT;
         done_q  <= 1'b0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         mask_q  <= mask_d;
         if (bus.i_clr) begin
            k_q    <= '0;
            mode_q <= MODE_LEFT;
         end else if (load) begin
            k_q    <= KW'(CW - 1);
            mode_q <= bus.i_mode;
         end else if (step) begin
            k_q    <= k_q - 1'b1;
         end
      end
   end

   // DONE first loads the result, then waits for trig to fall,
   // so a trig dropped during BUILD still sees one result.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.i_trig) state_d = BUILD;
         BUILD:   if (k_q == '0) state_d = DONE;
         DONE:    if (done_q && !bus.i_trig) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.i_clr) state_d = IDLE;
   end

   always_comb begin
      for (int i = 0; i < W; i++) rev[i] = therm_a[W-1-i];
      res = '0;
      unique case (mode_q)
         MODE_LEFT:      res = rev;
         MODE_RIGHT:     res = therm_a;
         MODE_RANGE:     res = therm_a & ~therm_b;
         MODE_INV_RANGE: res = ~(therm_a & ~therm_b);
         default:        res = '0;
      endcase
   end

   always_comb begin
      done_d = done_q;
      mask_d = mask_q;
      if (bus.i_clr) begin
         done_d = 1'b0;
         mask_d = '0;
      end else if (state_q == DONE && !done_q) begin
         done_d = 1'b1;
         mask_d = res;
      end else if (state_q == DONE && !bus.i_trig) begin
         done_d = 1'b0;
         mask_d = '0;
      end
   end

   assign bus.o_busy = (state_q == BUILD);
   assign bus.o_done = done_q;
   assign bus.o_mask = mask_q;

endmodule
